// File: rtl/adder_pipe_unit.sv
// adder_pipe_unit
// Two-stage pipelined add/subtract unit with four operation modes
// (add, subtract, unsigned saturating add, signed saturating add).
// The carry chain is cut between the low and the high operand halves:
// stage 1 resolves the low half and its carry/borrow, and stage 2 resolves
// the high half and applies the mode rules. Valid/ready handshakes are used
// on both sides. The pipeline holds at most two transactions.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   operand transaction present
//   in_ready   unit accepts the operand transaction this cycle
//   a, b       WIDTH-bit operands
//   mode       00 add, 01 sub (a-b), 10 unsigned sat add, 11 signed sat add
//   out_valid  result present
//   out_ready  consumer accepts the result
//   sum        WIDTH+1-bit result
//   ovf        overflow / borrow / saturation flag
module adder_pipe_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic             ovf
);

   localparam int LO = WIDTH / 2;
   localparam int HI = WIDTH - LO;

   localparam logic [1:0] MODE_ADD  = 2'b00;
   localparam logic [1:0] MODE_SUB  = 2'b01;
   localparam logic [1:0] MODE_USAT = 2'b10;
   localparam logic [1:0] MODE_SSAT = 2'b11;

   // Saturation value for the signed mode, already sign-extended to WIDTH+1 bits.
   function automatic logic [WIDTH:0] ssat_limit(input logic neg);
      logic [WIDTH:0] lim;
      if (neg) begin
         lim = {2'b11, {(WIDTH-1){1'b0}}};
      end else begin
         lim = {2'b00, {(WIDTH-1){1'b1}}};
      end
      return lim;
   endfunction

   // Signed overflow: both operands share a sign that the result does not.
   function automatic logic signed_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   // Stage-1 state
   logic              s1_valid_r;
   logic [LO-1:0]     s1_lo_r;
   logic              s1_carry_r;
   logic [HI-1:0]     s1_a_hi_r;
   logic [HI-1:0]     s1_b_hi_r;
   logic [1:0]        s1_mode_r;

   // Stage-2 (output) state
   logic              out_valid_r;
   logic [WIDTH:0]    sum_r;
   logic              ovf_r;

   // Combinational helpers
   logic              s2_load_s;
   logic              in_xfer_s;
   logic [LO:0]       lo_res_s;
   logic [HI:0]       hi_res_s;
   logic [WIDTH-1:0]  raw_s;
   logic [WIDTH:0]    sum_nxt_s;
   logic              ovf_nxt_s;

   assign s2_load_s = ~out_valid_r | out_ready;
   assign in_ready  = reset & (~s1_valid_r | s2_load_s);
   assign in_xfer_s = in_valid & in_ready;

   assign out_valid = out_valid_r;
   assign sum       = sum_r;
   assign ovf       = ovf_r;

   // Low half of the operation; bit LO is the carry (add) or borrow (sub).
   always_comb begin
      lo_res_s = {(LO+1){1'b0}};
      if (mode == MODE_SUB) begin
         lo_res_s = {1'b0, a[LO-1:0]} - {1'b0, b[LO-1:0]};
      end else begin
         lo_res_s = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]};
      end
   end

   // High half from the registered carry/borrow; bit HI is the full carry-out or borrow-out.
   always_comb begin
      hi_res_s = {(HI+1){1'b0}};
      if (s1_mode_r == MODE_SUB) begin
         hi_res_s = {1'b0, s1_a_hi_r} - {1'b0, s1_b_hi_r} - {{HI{1'b0}}, s1_carry_r};
      end else begin
         hi_res_s = {1'b0, s1_a_hi_r} + {1'b0, s1_b_hi_r} + {{HI{1'b0}}, s1_carry_r};
      end
   end

   assign raw_s = {hi_res_s[HI-1:0], s1_lo_r};

   // Mode rules applied to the completed raw result.
   always_comb begin
      sum_nxt_s = {(WIDTH+1){1'b0}};
      ovf_nxt_s = 1'b0;
      case (s1_mode_r)
         MODE_ADD, MODE_SUB: begin
            sum_nxt_s = {hi_res_s[HI], raw_s};
            ovf_nxt_s = hi_res_s[HI];
         end
         MODE_USAT: begin
            if (hi_res_s[HI]) begin
               sum_nxt_s = {1'b0, {WIDTH{1'b1}}};
               ovf_nxt_s = 1'b1;
            end else begin
               sum_nxt_s = {1'b0, raw_s};
               ovf_nxt_s = 1'b0;
            end
         end
         MODE_SSAT: begin
            if (signed_ovf(s1_a_hi_r[HI-1], s1_b_hi_r[HI-1], raw_s[WIDTH-1])) begin
               // Overflow direction follows the common operand sign.
               sum_nxt_s = ssat_limit(s1_a_hi_r[HI-1]);
               ovf_nxt_s = 1'b1;
            end else begin
               sum_nxt_s = {raw_s[WIDTH-1], raw_s};
               ovf_nxt_s = 1'b0;
            end
         end
         default: begin
            sum_nxt_s = {hi_res_s[HI], raw_s};
            ovf_nxt_s = hi_res_s[HI];
         end
      endcase
   end

   // Stage-1 register: captures low-half result and upper operand halves on an input transfer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid_r <= 1'b0;
         s1_lo_r    <= {LO{1'b0}};
         s1_carry_r <= 1'b0;
         s1_a_hi_r  <= {HI{1'b0}};
         s1_b_hi_r  <= {HI{1'b0}};
         s1_mode_r  <= 2'b00;
      end else if (in_xfer_s) begin
         s1_valid_r <= 1'b1;
         s1_lo_r    <= lo_res_s[LO-1:0];
         s1_carry_r <= lo_res_s[LO];
         s1_a_hi_r  <= a[WIDTH-1:LO];
         s1_b_hi_r  <= b[WIDTH-1:LO];
         s1_mode_r  <= mode;
      end else if (s2_load_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // Stage-2 register: loads when empty or when the current result is being consumed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_r <= 1'b0;
         sum_r       <= {(WIDTH+1){1'b0}};
         ovf_r       <= 1'b0;
      end else if (s2_load_s) begin
         out_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            sum_r <= sum_nxt_s;
            ovf_r <= ovf_nxt_s;
         end
      end
   end

endmodule

// File: tb/tb_adder_pipe_unit.sv
// Bench for adder_pipe_unit: four instances (WIDTH 8, 2, 7, 32) are driven
// from one process. A reference model computes each result directly from the
// arithmetic mode rules; a scoreboard of accepted transactions predicts
// out_valid, in_ready and the result of every instance on every cycle.
module tb_adder_pipe_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] a_s [4];
   logic [63:0] b_s [4];
   logic [1:0]  mode_s [4];
   logic        in_valid_s [4];
   logic        out_ready_s [4];
   wire         in_ready_w [4];
   wire         out_valid_w [4];
   wire         ovf_w [4];
   wire  [64:0] sum_w [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int W = (g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 7 : 32;
      wire [W:0] sum_n;
      adder_pipe_unit #(.WIDTH(W)) u_dut (
         .clk       (clk),
         .reset     (rst_n),
         .in_valid  (in_valid_s[g]),
         .in_ready  (in_ready_w[g]),
         .a         (a_s[g][W-1:0]),
         .b         (b_s[g][W-1:0]),
         .mode      (mode_s[g]),
         .out_valid (out_valid_w[g]),
         .out_ready (out_ready_s[g]),
         .sum       (sum_n),
         .ovf       (ovf_w[g])
      );
      assign sum_w[g] = {{(64-W){1'b0}}, sum_n};
   end

   function automatic int width_of(input int i);
      case (i)
         0: return 8;
         1: return 2;
         2: return 7;
         default: return 32;
      endcase
   endfunction

   function automatic logic [65:0] mask_of(input int w);
      return (66'd1 << w) - 66'd1;
   endfunction

   // Reference: returns {ovf, sum[64:0]} straight from the mode rules.
   function automatic logic [65:0] model(input int w, input logic [63:0] a,
                                         input logic [63:0] b, input logic [1:0] mode);
      logic [65:0] m, ua, ub, t;
      logic [64:0] s;
      logic        o;
      longint      va, vb, vs, lim;
      m  = mask_of(w);
      ua = {2'b00, a} & m;
      ub = {2'b00, b} & m;
      s  = 65'd0;
      o  = 1'b0;
      case (mode)
         2'b00: begin
            t = ua + ub; s = t[64:0]; o = (t > m);
         end
         2'b01: begin
            o = (ua < ub);
            t = ((ua - ub) & m) | ({65'd0, o} << w);
            s = t[64:0];
         end
         2'b10: begin
            t = ua + ub;
            if (t > m) begin s = m[64:0]; o = 1'b1; end
            else begin s = t[64:0]; o = 1'b0; end
         end
         default: begin
            lim = longint'(64'd1) << (w - 1);
            va  = longint'(ua[63:0]);
            vb  = longint'(ub[63:0]);
            if (va >= lim) va = va - (lim * 2);
            if (vb >= lim) vb = vb - (lim * 2);
            vs = va + vb;
            if (vs > lim - 1) begin vs = lim - 1; o = 1'b1; end
            else if (vs < -lim) begin vs = -lim; o = 1'b1; end
            else o = 1'b0;
            t = 66'(vs) & ((m << 1) | 66'd1);
            s = t[64:0];
         end
      endcase
      return {o, s};
   endfunction

   int          n_chk;
   int          n_pass;
   int          cyc;
   logic [65:0] sb_v [4][256];
   int          sb_t [4][256];
   int          hd [4];
   int          tl [4];
   int          outs [4];
   logic        acc [4];

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Output check against the scoreboard; called once per cycle at the falling edge.
   task automatic compare();
      logic [65:0] e;
      logic        exp_v;
      for (int i = 0; i < 4; i++) begin
         // A result becomes visible the edge after the edge that accepted it.
         exp_v = (tl[i] != hd[i]) && (cyc - sb_t[i][hd[i] % 256] >= 1);
         chk($sformatf("out_valid[%0d]", i), {65'd0, out_valid_w[i]}, {65'd0, exp_v});
         if (out_valid_w[i] && exp_v) begin
            e = sb_v[i][hd[i] % 256];
            chk($sformatf("sum[%0d]", i), {1'b0, sum_w[i]}, {1'b0, e[64:0]});
            chk($sformatf("ovf[%0d]", i), {65'd0, ovf_w[i]}, {65'd0, e[65]});
         end
      end
   endtask

   // One clock cycle with the stimulus already applied at the falling edge.
   task automatic step();
      logic exp_ir;
      #1;
      for (int i = 0; i < 4; i++) begin
         exp_ir = !(((tl[i] - hd[i]) == 2) && !out_ready_s[i]);
         chk($sformatf("in_ready[%0d]", i), {65'd0, in_ready_w[i]}, {65'd0, exp_ir});
         acc[i] = in_valid_s[i] && in_ready_w[i];
         if (out_valid_w[i] && out_ready_s[i] && (tl[i] != hd[i])) begin
            hd[i]++;
            outs[i]++;
         end
         if (acc[i]) begin
            sb_v[i][tl[i] % 256] = model(width_of(i), a_s[i], b_s[i], mode_s[i]);
            sb_t[i][tl[i] % 256] = cyc + 1;
            tl[i]++;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      compare();
   endtask

   logic [7:0] dv_a [10] = '{8'd200, 8'd3, 8'd5, 8'd9, 8'd200, 8'd100, 8'd255, 8'h70, 8'h80, 8'hFE};
   logic [7:0] dv_b [10] = '{8'd100, 8'd4, 8'd7, 8'd9, 8'd100, 8'd100, 8'd0,   8'h20, 8'hFF, 8'h01};
   logic [1:0] dv_m [10] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};

   initial begin
      int          sent, base;
      int          vld_cnt [4];
      int          acc_cnt [4];
      logic [65:0] r;
      n_chk = 0; n_pass = 0; cyc = 0; rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b1;
         a_s[i] = 64'd0; b_s[i] = 64'd0; mode_s[i] = 2'b00;
         hd[i] = 0; tl[i] = 0; outs[i] = 0; vld_cnt[i] = 0; acc_cnt[i] = 0;
      end

      // Hand-computed expectations that pin the reference model.
      chk("pin add 200+100",  model(8, 64'd200, 64'd100, 2'b00), {1'b1, 65'h12C});
      chk("pin add 3+4",      model(8, 64'd3,   64'd4,   2'b00), {1'b0, 65'h007});
      chk("pin sub 5-7",      model(8, 64'd5,   64'd7,   2'b01), {1'b1, 65'h1FE});
      chk("pin sub 9-9",      model(8, 64'd9,   64'd9,   2'b01), {1'b0, 65'h000});
      chk("pin usat 200+100", model(8, 64'd200, 64'd100, 2'b10), {1'b1, 65'h0FF});
      chk("pin usat 100+100", model(8, 64'd100, 64'd100, 2'b10), {1'b0, 65'h0C8});
      chk("pin usat 255+0",   model(8, 64'd255, 64'd0,   2'b10), {1'b0, 65'h0FF});
      chk("pin ssat 70+20",   model(8, 64'h70,  64'h20,  2'b11), {1'b1, 65'h07F});
      chk("pin ssat 80+FF",   model(8, 64'h80,  64'hFF,  2'b11), {1'b1, 65'h180});
      chk("pin ssat FE+01",   model(8, 64'hFE,  64'h01,  2'b11), {1'b0, 65'h1FF});
      chk("pin w2 ssat 1+1",  model(2, 64'd1,   64'd1,   2'b11), {1'b1, 65'h1});
      chk("pin w7 sub 0-1",   model(7, 64'd0,   64'd1,   2'b01), {1'b1, 65'hFF});

      // Reset state.
      #2;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst out_valid[%0d]", i), {65'd0, out_valid_w[i]}, 66'd0);
         chk($sformatf("rst sum[%0d]", i),       {1'b0, sum_w[i]},        66'd0);
         chk($sformatf("rst ovf[%0d]", i),       {65'd0, ovf_w[i]},       66'd0);
         chk($sformatf("rst in_ready[%0d]", i),  {65'd0, in_ready_w[i]},  66'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors, back to back on the 8-bit instance.
      for (int v = 0; v < 10; v++) begin
         in_valid_s[0] = 1'b1;
         a_s[0] = {56'd0, dv_a[v]}; b_s[0] = {56'd0, dv_b[v]}; mode_s[0] = dv_m[v];
         step();
      end
      in_valid_s[0] = 1'b0;
      repeat (3) step();
      chk("directed drained", 66'(tl[0] - hd[0]), 66'd0);

      // Backpressure: out_ready low for cycles 3-5 of a 6-transaction stream.
      base = outs[0];
      sent = 0;
      for (int j = 0; j < 16; j++) begin
         in_valid_s[0]  = (sent < 6);
         a_s[0]         = 64'(37 * sent + 11);
         b_s[0]         = 64'(53 * sent + 90);
         mode_s[0]      = 2'(sent);
         out_ready_s[0] = !(j >= 2 && j <= 4);
         step();
         if (acc[0]) sent++;
      end
      chk("bp accepted", 66'(sent), 66'd6);
      chk("bp emerged",  66'(outs[0] - base), 66'd6);

      // Reset with two transactions in flight.
      in_valid_s[0] = 1'b1; a_s[0] = 64'd40; b_s[0] = 64'd50; mode_s[0] = 2'b00;
      out_ready_s[0] = 1'b1;
      step();
      a_s[0] = 64'd7; out_ready_s[0] = 1'b0;
      step();
      chk("mid in flight", 66'(tl[0] - hd[0]), 66'd2);
      in_valid_s[0] = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst out_valid", {65'd0, out_valid_w[0]}, 66'd0);
      chk("mid rst sum",       {1'b0, sum_w[0]},        66'd0);
      chk("mid rst ovf",       {65'd0, ovf_w[0]},       66'd0);
      chk("mid rst in_ready",  {65'd0, in_ready_w[0]},  66'd0);
      for (int i = 0; i < 4; i++) hd[i] = tl[i];
      @(negedge clk);
      rst_n = 1'b1;
      out_ready_s[0] = 1'b1; in_valid_s[0] = 1'b1;
      a_s[0] = 64'd1; b_s[0] = 64'd1; mode_s[0] = 2'b00;
      step();
      in_valid_s[0] = 1'b0;
      step();
      chk("fresh 1+1 valid", {65'd0, out_valid_w[0]}, 66'd1);
      chk("fresh 1+1 sum",   {1'b0, sum_w[0]},        66'h002);

      // Width sweep with random operands, modes and out_ready.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) begin
            r = mask_of(width_of(i));
            in_valid_s[i]  = ($urandom_range(0, 3) != 0);
            a_s[i]         = {$urandom, $urandom} & r[63:0];
            b_s[i]         = {$urandom, $urandom} & r[63:0];
            mode_s[i]      = 2'($urandom_range(0, 3));
            out_ready_s[i] = (c < 60) ? 1'b1 : ($urandom_range(0, 2) != 0);
         end
         step();
         if (c < 60) begin
            for (int i = 0; i < 4; i++) begin
               if (in_valid_s[i]) vld_cnt[i]++;
               if (acc[i]) acc_cnt[i]++;
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         in_valid_s[i] = 1'b0; out_ready_s[i] = 1'b1;
      end
      repeat (3) step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("throughput[%0d]", i), 66'(acc_cnt[i]), 66'(vld_cnt[i]));
         chk($sformatf("sweep drained[%0d]", i), 66'(tl[i] - hd[i]), 66'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
